// File: rtl/a51_pkg.sv
// Shared constants for the A5/1 keystream core: register geometry, taps, clock bits, FSM states.
package a51_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    // Tap positions as bit masks; feedback is the XOR of the masked bits.
    localparam logic [31:0] R1_TAPS = (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 17) | (32'd1 << 18);
    localparam logic [31:0] R2_TAPS = (32'd1 << 20) | (32'd1 << 21);
    localparam logic [31:0] R3_TAPS = (32'd1 << 7) | (32'd1 << 20) | (32'd1 << 21) | (32'd1 << 22);

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        GEN,
        DONE
    } a51_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/a51_lfsr.sv
// One A5/1 shift register: steps on demand, XORs an injected bit into the feedback.
module a51_lfsr
    import a51_pkg::*;
#(
    parameter int          LEN      = 19,
    parameter logic [31:0] TAP_MASK = R1_TAPS,
    parameter int          CLK_BIT  = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_step,
    input  logic i_inj,
    output logic o_clk_bit,
    output logic o_msb,
    output logic o_msb_nxt
);

    localparam logic [LEN-1:0] MASK = TAP_MASK[LEN-1:0];

    logic [LEN-1:0] r_state;
    logic [LEN-1:0] w_state_nxt;
    logic           w_fb;

    assign w_fb        = (^(r_state & MASK)) ^ i_inj;
    assign w_state_nxt = i_step ? {r_state[LEN-2:0], w_fb} : r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_state <= '0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_clk_bit = r_state[CLK_BIT];
    assign o_msb     = r_state[LEN-1];
    // Keystream bits are defined on the post-step state, so expose it combinationally.
    assign o_msb_nxt = w_state_nxt[LEN-1];

endmodule

// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator: key/frame load, majority-clocked mixing, packed keystream beats.
//   state      | meaning
//   IDLE       | waiting for start
//   LOAD_KEY   | all registers stepped, key bit injected
//   LOAD_FRAME | all registers stepped, frame bit injected
//   MIX        | majority-clocked discard steps
//   GEN        | majority steps packed into beats under valid/ready
//   DONE       | one-cycle done pulse
module a51_keystream_gen
    import a51_pkg::*;
#(
    parameter int KEY_BITS    = 64,
    parameter int FRAME_BITS  = 22,
    parameter int MIX_CYCLES  = 100,
    parameter int STREAM_BITS = 228,
    parameter int OUT_W       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [KEY_BITS-1:0]   i_key,
    input  logic [FRAME_BITS-1:0] i_frame,
    output logic                  o_busy,
    output logic [OUT_W-1:0]      o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_done
);

    localparam int CNT_MAX = max_int(max_int(KEY_BITS, FRAME_BITS), max_int(MIX_CYCLES, STREAM_BITS));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_W - 1);

    a51_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_bits_left;
    logic [KEY_BITS-1:0]   r_key;
    logic [FRAME_BITS-1:0] r_frame;
    logic [OUT_W-1:0]      r_acc;
    logic [OUT_W-1:0]      r_out_data;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;

    logic w_clr, w_adv, w_gen_step, w_load, w_maj_en, w_inj, w_maj, w_bit;
    logic w_c1, w_c2, w_c3, w_m1, w_m2, w_m3, w_n1, w_n2, w_n3;
    logic w_step1, w_step2, w_step3;
    logic [OUT_W-1:0] w_acc_nxt;

    assign w_clr      = (r_state == IDLE) && i_start;
    assign w_adv      = !r_out_valid || i_out_ready;
    assign w_gen_step = (r_state == GEN) && w_adv && (r_bits_left != '0);
    assign w_load     = (r_state == LOAD_KEY) || (r_state == LOAD_FRAME);
    assign w_maj_en   = (r_state == MIX) || w_gen_step;
    assign w_inj      = (r_state == LOAD_KEY) ? r_key[0] :
                        (r_state == LOAD_FRAME) ? r_frame[0] : 1'b0;

    assign w_maj   = (w_c1 & w_c2) | (w_c1 & w_c3) | (w_c2 & w_c3);
    assign w_step1 = w_load || (w_maj_en && (w_c1 == w_maj));
    assign w_step2 = w_load || (w_maj_en && (w_c2 == w_maj));
    assign w_step3 = w_load || (w_maj_en && (w_c3 == w_maj));
    assign w_bit   = w_n1 ^ w_n2 ^ w_n3;

    a51_lfsr #(.LEN(R1_LEN), .TAP_MASK(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_step(w_step1), .i_inj(w_inj),
        .o_clk_bit(w_c1), .o_msb(w_m1), .o_msb_nxt(w_n1)
    );
    a51_lfsr #(.LEN(R2_LEN), .TAP_MASK(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_step(w_step2), .i_inj(w_inj),
        .o_clk_bit(w_c2), .o_msb(w_m2), .o_msb_nxt(w_n2)
    );
    a51_lfsr #(.LEN(R3_LEN), .TAP_MASK(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_step(w_step3), .i_inj(w_inj),
        .o_clk_bit(w_c3), .o_msb(w_m3), .o_msb_nxt(w_n3)
    );

    // Current MSBs are not needed here; the output bit uses the post-step values.
    logic w_unused;
    assign w_unused = w_m1 ^ w_m2 ^ w_m3;

    always_comb begin
        w_acc_nxt = r_acc;
        for (int i = 0; i < OUT_W; i++) begin
            if (r_idx == IDX_W'(i)) w_acc_nxt[i] = w_bit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bits_left <= '0;
            r_key       <= '0;
            r_frame     <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= LOAD_KEY;
                        r_key   <= i_key;
                        r_frame <= i_frame;
                        r_cnt   <= CNT_W'(KEY_BITS - 1);
                        r_busy  <= 1'b1;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                LOAD_KEY: begin
                    r_key <= r_key >> 1;
                    if (r_cnt == '0) begin
                        r_state <= LOAD_FRAME;
                        r_cnt   <= CNT_W'(FRAME_BITS - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                LOAD_FRAME: begin
                    r_frame <= r_frame >> 1;
                    if (r_cnt == '0) begin
                        r_state <= MIX;
                        r_cnt   <= CNT_W'(MIX_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                MIX: begin
                    if (r_cnt == '0) begin
                        r_state     <= GEN;
                        r_bits_left <= CNT_W'(STREAM_BITS);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                GEN: begin
                    if (w_gen_step) begin
                        r_bits_left <= r_bits_left - CNT_W'(1);
                        if (r_idx == IDX_LAST) begin
                            r_out_data  <= w_acc_nxt;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_idx       <= '0;
                        end else begin
                            r_acc       <= w_acc_nxt;
                            r_idx       <= r_idx + IDX_W'(1);
                            r_out_valid <= 1'b0;
                        end
                    end else if (w_adv && r_out_valid) begin
                        // Final beat handed off; nothing left to generate.
                        r_out_valid <= 1'b0;
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;

endmodule

// File: tb/tb_a51_keystream_gen.sv
// Directed bench for a51_keystream_gen: bit-serial instance (defaults) and an 8-bit beat instance.
module tb_a51_keystream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_busy, a_valid, a_ready, a_done;
    logic [63:0] a_key;
    logic [21:0] a_frame;
    logic [0:0]  a_data;
    logic        b_start, b_busy, b_valid, b_ready, b_done;
    logic [63:0] b_key;
    logic [21:0] b_frame;
    logic [7:0]  b_data;

    a51_keystream_gen dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_key(a_key), .i_frame(a_frame),
        .o_busy(a_busy), .o_out_data(a_data), .o_out_valid(a_valid),
        .i_out_ready(a_ready), .o_done(a_done)
    );

    a51_keystream_gen #(.OUT_W(8), .STREAM_BITS(232)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_key(b_key), .i_frame(b_frame),
        .o_busy(b_busy), .o_out_data(b_data), .o_out_valid(b_valid),
        .i_out_ready(b_ready), .o_done(b_done)
    );

    localparam logic [63:0] KEY = 64'h1223456789ABCDEF;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] exp_vec, got_vec;
    int   c_nbits, c_first_k, c_done_k, c_stall_err;
    logic c_busy_k0, c_busy_done, c_done_after;
    logic c_abort_valid, c_abort_busy, c_abort_done;

    // Reference A5/1: load key then frame with all registers stepped, 100 discard steps, then output.
    task automatic model(input logic [63:0] k, input logic [21:0] f, input int nbits);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic        b, m;
        r1 = '0; r2 = '0; r3 = '0; exp_vec = '0;
        for (int i = 0; i < 86; i++) begin
            b  = (i < 64) ? k[i] : f[i-64];
            r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ b};
            r2 = {r2[20:0], r2[20] ^ r2[21] ^ b};
            r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ b};
        end
        for (int i = 0; i < 100 + nbits; i++) begin
            m = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
            if (r1[8] == m)  r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18]};
            if (r2[10] == m) r2 = {r2[20:0], r2[20] ^ r2[21]};
            if (r3[10] == m) r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22]};
            if (i >= 100) exp_vec[i-100] = r1[18] ^ r2[21] ^ r3[22];
        end
    endtask

    // Runs one burst on the bit-serial instance and records what it saw; the tests judge the results.
    task automatic collect_a(input logic [63:0] k, input logic [21:0] f, input int ready_pct,
                             input int poke_k, input int abort_at);
        logic prev_stall;
        logic prev_data;
        got_vec = '0; c_nbits = 0; c_first_k = -1; c_done_k = -1; c_stall_err = 0;
        c_busy_done = 1'bx; c_done_after = 1'bx;
        a_key = k; a_frame = f; a_start = 1'b1; a_ready = 1'b0;
        @(posedge clk); #1;
        a_start = 1'b0; a_key = ~k; a_frame = ~f;
        c_busy_k0 = a_busy;
        prev_stall = 1'b0; prev_data = 1'b0;
        for (int kk = 1; kk <= 6000; kk++) begin
            @(posedge clk); #1;
            if (prev_stall && (a_valid !== 1'b1 || a_data[0] !== prev_data)) c_stall_err++;
            if (a_valid === 1'b1 && c_first_k < 0) c_first_k = kk;
            if (a_done === 1'b1) begin
                c_done_k = kk; c_busy_done = a_busy;
                break;
            end
            a_start = (kk == poke_k);
            if (abort_at >= 0 && c_nbits == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                c_abort_valid = a_valid; c_abort_busy = a_busy; c_abort_done = a_done;
                rst = 1'b0; a_ready = 1'b0;
                return;
            end
            a_ready    = ($urandom_range(0, 99) < ready_pct);
            prev_stall = a_valid && !a_ready;
            prev_data  = a_data[0];
            if (a_valid === 1'b1 && a_ready) begin
                got_vec[c_nbits] = a_data[0];
                c_nbits++;
            end
        end
        a_ready = 1'b0;
        @(posedge clk); #1;
        c_done_after = a_done;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_start = 1'b1; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        a_key = KEY; a_frame = 22'h134; b_key = '0; b_frame = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
        n_checks++; if (a_data !== 1'b0)  begin n_fail++; $display("FAIL reset_data: got %h expected 0", a_data); end
        n_checks++; if (a_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", a_done); end
        n_checks++; if (b_data !== 8'h00) begin n_fail++; $display("FAIL reset_wide_data: got %h expected 00", b_data); end
        rst = 1'b0; a_start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL start_under_rst: busy %b expected 0", a_busy); end
    endtask

    task automatic test_zero_stream();
        collect_a(64'h0, 22'h0, 100, -1, -1);
        n_checks++; if (c_busy_k0 !== 1'b1) begin n_fail++; $display("FAIL zero_busy_after_start: got %b expected 1", c_busy_k0); end
        n_checks++; if (c_first_k != 187) begin n_fail++; $display("FAIL zero_first_valid: got T+%0d expected T+187", c_first_k); end
        n_checks++; if (c_done_k != 415) begin n_fail++; $display("FAIL zero_done_time: got T+%0d expected T+415", c_done_k); end
        n_checks++; if (c_nbits != 228) begin n_fail++; $display("FAIL zero_beats: got %0d expected 228", c_nbits); end
        n_checks++; if (got_vec !== '0) begin n_fail++; $display("FAIL zero_stream: got %h expected 0", got_vec); end
        n_checks++; if (c_busy_done !== 1'b0) begin n_fail++; $display("FAIL zero_busy_at_done: got %b expected 0", c_busy_done); end
        n_checks++; if (c_done_after !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse_width: got %b expected 0", c_done_after); end
    endtask

    task automatic test_model_stream();
        model(KEY, 22'h134, 228);
        collect_a(KEY, 22'h134, 100, -1, -1);
        n_checks++; if (c_nbits != 228) begin n_fail++; $display("FAIL key_beats: got %0d expected 228", c_nbits); end
        n_checks++; if (got_vec !== exp_vec) begin n_fail++; $display("FAIL key_stream: got %h expected %h", got_vec, exp_vec); end
        n_checks++; if (exp_vec === '0) begin n_fail++; $display("FAIL key_model_nonzero: got %h expected nonzero", exp_vec); end
    endtask

    task automatic test_wide_beats();
        int nb, first_k, done_k;
        model(KEY, 22'h134, 232);
        got_vec = '0; nb = 0; first_k = -1; done_k = -1;
        b_key = KEY; b_frame = 22'h134; b_start = 1'b1; b_ready = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0; b_key = '0; b_frame = '0;
        for (int kk = 1; kk <= 2000; kk++) begin
            @(posedge clk); #1;
            if (b_done === 1'b1) begin done_k = kk; break; end
            if (b_valid === 1'b1) begin
                if (first_k < 0) first_k = kk;
                for (int j = 0; j < 8; j++) got_vec[nb*8+j] = b_data[j];
                nb++;
            end
        end
        b_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (first_k != 194) begin n_fail++; $display("FAIL wide_first_valid: got T+%0d expected T+194", first_k); end
        n_checks++; if (nb != 29) begin n_fail++; $display("FAIL wide_beats: got %0d expected 29", nb); end
        n_checks++; if (done_k != 419) begin n_fail++; $display("FAIL wide_done_time: got T+%0d expected T+419", done_k); end
        n_checks++; if (got_vec !== exp_vec) begin n_fail++; $display("FAIL wide_stream: got %h expected %h", got_vec, exp_vec); end
    endtask

    task automatic test_random_ready();
        model(KEY, 22'h134, 228);
        collect_a(KEY, 22'h134, 30, -1, -1);
        n_checks++; if (c_stall_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", c_stall_err); end
        n_checks++; if (c_nbits != 228) begin n_fail++; $display("FAIL stall_beats_at_done: got %0d expected 228", c_nbits); end
        n_checks++; if (got_vec !== exp_vec) begin n_fail++; $display("FAIL stall_stream: got %h expected %h", got_vec, exp_vec); end
        n_checks++; if (c_done_k < 0) begin n_fail++; $display("FAIL stall_done_seen: got none expected pulse"); end
    endtask

    task automatic test_start_in_mix_and_abort();
        model(KEY, 22'h134, 228);
        collect_a(KEY, 22'h134, 100, 120, -1);
        n_checks++; if (got_vec !== exp_vec) begin n_fail++; $display("FAIL mix_start_stream: got %h expected %h", got_vec, exp_vec); end
        n_checks++; if (c_done_k != 415) begin n_fail++; $display("FAIL mix_start_done_time: got T+%0d expected T+415", c_done_k); end
        collect_a(KEY, 22'h134, 100, -1, 50);
        n_checks++; if (c_abort_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", c_abort_valid); end
        n_checks++; if (c_abort_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", c_abort_busy); end
        n_checks++; if (c_abort_done !== 1'b0 || c_done_k != -1) begin
            n_fail++; $display("FAIL abort_no_done: got done=%b at T+%0d expected none", c_abort_done, c_done_k);
        end
        collect_a(KEY, 22'h134, 100, -1, -1);
        n_checks++; if (got_vec !== exp_vec) begin n_fail++; $display("FAIL restart_stream: got %h expected %h", got_vec, exp_vec); end
        n_checks++; if (c_first_k != 187) begin n_fail++; $display("FAIL restart_first_valid: got T+%0d expected T+187", c_first_k); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp0;
        model(KEY, 22'h000, 228);
        exp0 = exp_vec;
        collect_a(KEY, 22'h000, 100, -1, -1);
        n_checks++; if (got_vec !== exp_vec) begin n_fail++; $display("FAIL b2b_frame0: got %h expected %h", got_vec, exp_vec); end
        model(KEY, 22'h001, 228);
        collect_a(KEY, 22'h001, 100, -1, -1);
        n_checks++; if (got_vec !== exp_vec) begin n_fail++; $display("FAIL b2b_frame1: got %h expected %h", got_vec, exp_vec); end
        n_checks++; if (got_vec === exp0) begin n_fail++; $display("FAIL b2b_frames_differ: got %h for both frames", got_vec); end
        n_checks++; if (c_first_k != 187) begin n_fail++; $display("FAIL b2b_first_valid: got T+%0d expected T+187", c_first_k); end
    endtask

    initial begin
        test_reset();
        test_zero_stream();
        test_model_stream();
        test_wide_beats();
        test_random_ready();
        test_start_in_mix_and_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/a51_keystream_gen.md
# a51_keystream_gen

Parametrised A5/1-style keystream generator with three majority-clocked LFSRs (R1 19b, R2 22b, R3 23b). It loads a key and frame number, runs the discard mixing phase, then emits a burst of keystream bits packed into OUT_W-bit beats over a valid/ready handshake. It sits between the key/frame control logic and the plaintext XOR stage of the cipher datapath. It supersedes the single-bit majority voter as the clocking core of the cipher.

## Interface
- KEY_BITS, 64: key bits loaded, key[0] first
- FRAME_BITS, 22: frame bits loaded, frame[0] first
- MIX_CYCLES, 100: majority-clocked discard cycles
- STREAM_BITS, 228: keystream bits per burst; must be a multiple of OUT_W
- OUT_W, 1: bits per output beat (1..32)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- key  in  KEY_BITS  session key, captured on accepted start
- frame  in  FRAME_BITS  frame number, captured on accepted start
- busy  out  1  high from the cycle after start is accepted until done
- out_data  out  OUT_W  keystream beat; first generated bit in bit 0
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat when out_valid && out_ready
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Registers and taps (feedback into bit 0, shift toward MSB):
  - R1: taps 13,16,17,18; clock bit 8.
  - R2: taps 20,21; clock bit 10.
  - R3: taps 7,20,21,22; clock bit 10.
- FSM states and transitions:
  - IDLE: on start, go to LOAD_KEY. Clear R1..R3 and capture key/frame in the same edge.
  - LOAD_KEY: KEY_BITS cycles. All three registers are clocked every cycle, and key bit i is XORed into the new bit 0 of each.
  - LOAD_FRAME: FRAME_BITS cycles, same as LOAD_KEY but using frame bits.
  - MIX: MIX_CYCLES cycles of majority clocking; output bits are discarded.
  - GEN: run until STREAM_BITS bits are generated and accepted.
  - DONE: one cycle with done=1, then go to IDLE.
- Majority clocking: m = maj(R1[8], R2[10], R3[10]). A register is clocked iff its clock bit equals m, so two or three registers step each cycle.
- Output bit: R1[18]^R2[21]^R3[22], taken from the register state after that cycle's step.
- GEN advance enable = !out_valid || out_ready.
  - Each advance does one majority step and shifts the resulting bit into the beat accumulator at position cnt.
  - After OUT_W bits, the beat moves to out_data and out_valid is set.
- Stall: while out_valid && !out_ready, the LFSRs, the accumulator and out_data hold.
- Counters are sized to the maximum of the parameter values. No wrap occurs within a burst.
- start while busy is ignored; key and frame are not recaptured.
- rst mid-operation aborts the burst immediately with no done pulse.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, done=0, state IDLE, R1..R3=0.
- Latency: start accepted at edge T; the first out_valid is seen at edge T + KEY_BITS + FRAME_BITS + MIX_CYCLES + OUT_W. With defaults this is T+187.
- Throughput: one beat per OUT_W cycles when out_ready is held high. Back-to-back acceptance costs no bubble.
- out_data and out_valid are registered. out_data is stable while out_valid && !out_ready.
- done is asserted the cycle after the final handshake, and busy falls in that same cycle.
- A start sampled in IDLE in the same cycle as rst is ignored; rst wins.

## Structure
- Shared package a51_pkg holds:
  - register lengths, tap index lists and clock-bit indices;
  - the FSM state enum (IDLE, LOAD_KEY, LOAD_FRAME, MIX, GEN, DONE).
- Sub-module a51_lfsr, parametrised by LEN, tap mask and clock bit:
  - inputs: step enable and injected bit;
  - outputs: the clock bit and the MSB.
- The top level instantiates three a51_lfsr and contains the majority vote, FSM, counters and beat packer.

## Test plan
- All-zero key and frame, out_ready=1, defaults: 228 beats of 0; first out_valid at T+187; done once at T+415.
- Key 0x1223456789ABCDEF, frame 0x134: all 228 bits match the bench's bit-exact A5/1 software model.
- OUT_W=8, STREAM_BITS=232, same key: 29 beats; the beat bit order matches the model (first bit in out_data[0]).
- out_ready random at 30% high: out_data is held during stalls; the stream equals the no-stall stream; done comes after beat 228.
- start pulsed during MIX: ignored, and the keystream is unchanged. Then rst asserted at GEN beat 50: out_valid=0 and busy=0 next cycle with no done; a new start regenerates the stream from the first bit.
- Two consecutive bursts with different frames (0x000, 0x001): each burst matches the model independently, with no state carried over.
